// File: rtl/mmu_sequencer.sv
// rtl/mmu_sequencer.sv - operand loader, skewed feeder and result drainer for an N x N systolic MMU
// Optional cycle counter enabled by defining MMU_SEQUENCER_PERF_EN.
module mmu_sequencer #(
    parameter int N         = 2,
    parameter int DRAIN_CYC = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16:0]         out_data,
    output logic                busy,
    output logic                start_pulse,
    output logic [8*N-1:0]      a_feed,
    output logic [8*N-1:0]      b_feed,
    input  logic [17*N*N-1:0]   c_res,
    output logic [15:0]         perf_cycles
);

    localparam int NN       = N * N;
    localparam int TOT      = 2 * NN;
    localparam int FEED_LEN = 3 * N - 2;
    localparam int CW       = 8;
    localparam int IW       = $clog2(TOT);
    localparam int RW       = $clog2(NN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     opnd_q [TOT];
    logic [16:0]    res_q [NN];
    logic [8*N-1:0] a_feed_q, a_feed_d;
    logic [8*N-1:0] b_feed_q, b_feed_d;
    logic           start_q, start_d;
    logic           accept;
    logic           capture;
    logic           last_hs;
    logic           feed_next;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = (state_q == S_OUT) ? res_q[cnt_q[RW-1:0]] : 17'd0;
    // The counter saturates at TOT in LOAD, giving one settle cycle before FEED.
    assign accept    = in_valid && in_ready && (cnt_q < CW'(TOT));
    assign last_hs   = (state_q == S_OUT) && out_ready && (cnt_q == CW'(NN - 1));
    assign capture   = (state_q == S_DRAIN) && (cnt_q == CW'(DRAIN_CYC - 1));

    assign start_pulse = start_q;
    assign a_feed      = a_feed_q;
    assign b_feed      = b_feed_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOAD;
                    cnt_d   = CW'(1);
                end
            end
            S_LOAD: begin
                if (cnt_q == CW'(TOT)) begin
                    state_d = S_FEED;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FEED: begin
                if (cnt_q == CW'(FEED_LEN - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (capture) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (last_hs) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (out_ready) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Feed lanes are computed from the next state so the registered outputs line up with k.
    always_comb begin
        feed_next = (state_d == S_FEED);
        start_d   = feed_next && (cnt_d == '0);
        a_feed_d  = '0;
        b_feed_d  = '0;
        for (int i = 0; i < N; i++) begin
            for (int m = 0; m < N; m++) begin
                if (feed_next && (cnt_d == CW'(i + m))) begin
                    a_feed_d[8*i +: 8] = opnd_q[i*N + m];
                    b_feed_d[8*i +: 8] = opnd_q[NN + m*N + i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            a_feed_q <= '0;
            b_feed_q <= '0;
            for (int t = 0; t < TOT; t++) opnd_q[t] <= '0;
            for (int e = 0; e < NN; e++) res_q[e] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            a_feed_q <= a_feed_d;
            b_feed_q <= b_feed_d;
            if (accept) opnd_q[cnt_q[IW-1:0]] <= in_data;
            if (capture) begin
                for (int e = 0; e < NN; e++) res_q[e] <= c_res[17*e +: 17];
            end
        end
    end

`ifdef MMU_SEQUENCER_PERF_EN
    logic [15:0] perf_cnt_q, perf_cnt_d;
    logic [15:0] perf_q;

    // The accepting cycle of the first byte counts as the operation's first cycle.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if ((state_q == S_IDLE) && accept) begin
            perf_cnt_d = 16'd1;
        end else if (busy && (perf_cnt_q != 16'hFFFF)) begin
            perf_cnt_d = perf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            if (last_hs) perf_q <= perf_cnt_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_mmu_sequencer.sv
// tb/tb_mmu_sequencer.sv - directed scoreboard bench for mmu_sequencer (N=2)
module tb_mmu_sequencer;
    localparam int N  = 2;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [16:0]   out_data;
    logic          busy;
    logic          start_pulse;
    logic [8*N-1:0]    a_feed;
    logic [8*N-1:0]    b_feed;
    logic [17*NN-1:0]  c_res;
    logic [15:0]   perf_cycles;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ma [NN];
    logic [7:0]  mb [NN];
    logic [16:0] sb [$];

    mmu_sequencer #(.N(N), .DRAIN_CYC(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .start_pulse(start_pulse),
        .a_feed(a_feed), .b_feed(b_feed), .c_res(c_res),
        .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_start"}, 32'(start_pulse), 0);
        chk({tag, "_a_feed"}, 32'(a_feed), 0);
        chk({tag, "_b_feed"}, 32'(b_feed), 0);
        chk({tag, "_perf"}, 32'(perf_cycles), 0);
    endtask

    task automatic setup_op();
        int acc;
        logic [16:0] r;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int m = 0; m < N; m++) acc += int'(ma[i*N+m]) * int'(mb[m*N+j]);
                r = 17'(acc);
                sb.push_back(r);
                c_res[17*(i*N+j) +: 17] = r;
            end
        end
    endtask

    task automatic load_op(input bit gap);
        for (int idx = 0; idx < 2*NN; idx++) begin
            if (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = (idx < NN) ? ma[idx] : mb[idx-NN];
            #1;
            chk("in_ready_load", 32'(in_ready), 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("busy_load_end", 32'(busy), 1);
        chk("start_before_feed", 32'(start_pulse), 0);
    endtask

    task automatic feed_phase(input bit check_feed, input bit junk);
        int m;
        logic [7:0] ea;
        logic [7:0] eb;
        for (int k = 0; k < 3*N-2; k++) begin
            @(negedge clk);
            in_valid = junk;
            in_data  = 8'hEE;
            #1;
            chk("start_pulse", 32'(start_pulse), (k == 0) ? 1 : 0);
            if (junk) chk("in_ready_feed", 32'(in_ready), 0);
            if (check_feed) begin
                for (int l = 0; l < N; l++) begin
                    m  = k - l;
                    ea = (m >= 0 && m < N) ? ma[l*N+m] : 8'd0;
                    eb = (m >= 0 && m < N) ? mb[m*N+l] : 8'd0;
                    chk("a_feed_lane", 32'(a_feed[8*l +: 8]), 32'(ea));
                    chk("b_feed_lane", 32'(b_feed[8*l +: 8]), 32'(eb));
                end
            end
        end
    endtask

    task automatic drain_phase(input bit junk);
        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            in_valid = junk;
            #1;
            chk("drain_out_valid", 32'(out_valid), 0);
            chk("drain_busy", 32'(busy), 1);
            chk("drain_feed_zero", 32'({a_feed, b_feed, start_pulse}), 0);
        end
    endtask

    task automatic out_phase(input int stall_len, input bit junk, input int exp_perf);
        int hs      = 0;
        int stalled = 0;
        bit garbled = 1'b0;
        for (int t = 0; t < 40 && sb.size() > 0; t++) begin
            @(negedge clk);
            in_valid  = junk;
            out_ready = !(hs == 1 && stalled < stall_len);
            #1;
            if (junk) chk("in_ready_out", 32'(in_ready), 0);
            if (out_valid && !garbled) begin
                c_res   = '1;
                garbled = 1'b1;
            end
            if (out_valid) begin
                if (!out_ready) begin
                    chk("stall_hold", 32'(out_data), 32'(sb[0]));
                    stalled++;
                end else begin
                    chk("result", 32'(out_data), 32'(sb.pop_front()));
                    hs++;
                end
            end
        end
        chk("results_left", sb.size(), 0);
        chk("stall_cycles", stalled, stall_len);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_out_valid", 32'(out_valid), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_in_ready", 32'(in_ready), 1);
`ifdef MMU_SEQUENCER_PERF_EN
        chk("perf_cycles", 32'(perf_cycles), exp_perf);
`else
        chk("perf_cycles", 32'(perf_cycles), exp_perf * 0);
`endif
    endtask

    task automatic run_op(input bit gap, input bit check_feed, input int stall_len, input bit junk);
        setup_op();
        load_op(gap);
        feed_phase(check_feed, junk);
        drain_phase(junk);
        out_phase(stall_len, junk, 20 + stall_len + (gap ? 7 : 0));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        c_res     = '0;
        #1;
        chk_reset("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        ma = '{8'd1, 8'd2, 8'd3, 8'd4};
        mb = '{8'd5, 8'd6, 8'd7, 8'd8};
        run_op(1'b0, 1'b1, 0, 1'b0);
        run_op(1'b0, 1'b0, 5, 1'b0);

        ma = '{8'd255, 8'd255, 8'd255, 8'd255};
        mb = '{8'd255, 8'd255, 8'd255, 8'd255};
        run_op(1'b1, 1'b1, 0, 1'b1);

        ma = '{8'd9, 8'd8, 8'd7, 8'd6};
        mb = '{8'd3, 8'd1, 8'd4, 8'd1};
        setup_op();
        load_op(1'b0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset("midfeed_reset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        for (int e = 0; e < NN; e++) begin
            ma[e] = 8'($urandom_range(0, 255));
            mb[e] = 8'($urandom_range(0, 255));
        end
        run_op(1'b0, 1'b1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmu_sequencer.md
MMU_SEQUENCER -- requirements
Module: mmu_sequencer

Interface
REQ-001 SHALL have parameter N, default 2, systolic array edge dimension (N x N PEs, N in 2..4).
REQ-002 SHALL have parameter DRAIN_CYC, default 3, cycles waited after the last skewed operand before results are captured.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, and in_data input 8, forming the operand byte stream.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1, and out_data output 17, forming the result stream.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have ports start_pulse  output  1, a_feed  output  8*N, b_feed  output  8*N, and c_res  input  17*N*N; these form the array side, and c_res is row-major with element (i,j) at bits [17*(i*N+j) +: 17].
REQ-009 SHALL have port perf_cycles  output  16  operation cycle count (see Configuration).

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, FEED, DRAIN, OUT, with one state change at most per clock.
REQ-011 IDLE->LOAD SHALL occur on the first accepted in_data byte; in_ready SHALL be 1 in IDLE and LOAD, and 0 otherwise.
REQ-012 A byte SHALL be accepted only when in_valid&&in_ready, with 2*N*N bytes per operation: A row-major, then B row-major, stored in internal registers.
REQ-013 LOAD->FEED SHALL occur on the cycle after the last byte is accepted; a stalled in_valid SHALL hold LOAD indefinitely.
REQ-014 FEED SHALL last exactly 3N-2 cycles, indexed k=0..3N-3; start_pulse SHALL be 1 only at k=0.
REQ-015 At cycle k, a_feed lane i SHALL equal A[i][k-i] when 0<=k-i<N and 0 otherwise, and b_feed lane j SHALL equal B[k-j][j] when 0<=k-j<N and 0 otherwise.
REQ-016 a_feed, b_feed and start_pulse SHALL be registered outputs, and SHALL be 0 outside FEED.
REQ-017 DRAIN SHALL last exactly DRAIN_CYC cycles; on its last cycle, all N*N c_res words SHALL be captured into result registers, then the FSM SHALL enter OUT.
REQ-018 OUT SHALL present results row-major; out_data SHALL be stable while out_valid&&!out_ready.
REQ-019 OUT SHALL advance one index per out_valid&&out_ready.
REQ-020 After the N*N-th handshake, the FSM SHALL return to IDLE, and out_valid SHALL be 0 in the following cycle.
REQ-021 out_valid SHALL be 1 only in OUT.
REQ-022 Captured results SHALL be immune to c_res changes after capture.
REQ-023 in_valid during FEED, DRAIN or OUT SHALL be ignored, with no byte consumed.
REQ-024 A new operation SHALL NOT begin in the same cycle as the final OUT handshake; the earliest accepted byte is in the next cycle.

Reset
REQ-025 On rst, the FSM SHALL enter IDLE immediately.
REQ-026 On rst, all counters, operand registers and result registers SHALL clear to 0.
REQ-027 Reset values SHALL be: in_ready=1, out_valid=0, out_data=0, busy=0, start_pulse=0, a_feed=0, b_feed=0, perf_cycles=0.
REQ-028 Reset asserted mid-operation SHALL abandon the operation with no partial results emitted; the next operation SHALL restart at A[0][0].

Configuration
REQ-029 With macro MMU_SEQUENCER_PERF_EN defined, a 16-bit counter SHALL clear on the first accepted byte of an operation.
REQ-030 With MMU_SEQUENCER_PERF_EN defined, the counter SHALL increment every cycle while busy, saturate at 16'hFFFF, and be copied to perf_cycles on the final OUT handshake, which it holds until the next completion or reset.
REQ-031 Without MMU_SEQUENCER_PERF_EN, perf_cycles SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-032 N=2 with A={1,2,3,4} and B={5,6,7,8}, with the array model producing the matrix product -> outputs 19,22,43,50 in order, and busy=0 after the last handshake.
REQ-033 N=2 feed check -> a_feed lane0 = 1,2,0,0 and lane1 = 0,3,4,0 over FEED k=0..3; start_pulse is high only at k=0.
REQ-034 N=2 with out_ready held at 0 for 5 cycles at the 2nd result -> out_data is held at 22 and no result is skipped or duplicated.
REQ-035 rst asserted during FEED at k=2 -> all outputs are at reset values immediately; a following full load produces correct results.
REQ-036 N=2 with in_valid gapped every other cycle, then in_valid held at 1 during FEED -> exactly 8 bytes are consumed and extra bytes are not accepted.
REQ-037 With MMU_SEQUENCER_PERF_EN and back-to-back handshakes throughout -> perf_cycles=8+1+4+3+4=20.
